// File: rtl/inert_spi_seq.sv
// Inertial sensor SPI sequencer: power-up wait, one-shot configuration, then a
// low/high register read pair per data-ready interrupt to build a yaw-rate sample.
module inert_spi_seq #(
   parameter int INIT_CYCLES = 65536
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        int_i,
   input  logic        done_i,
   input  logic [15:0] rd_data_i,
   output logic        wrt_o,
   output logic [15:0] wt_data_o,
   output logic [15:0] yaw_rt_o,
   output logic        vld_o
);
   // state    | meaning
   // PWR_WAIT | sensor power-up delay, counting to INIT_CYCLES-1
   // CFG1     | write 0x0D02, enable data-ready interrupt
   // CFG2     | write 0x1160, gyro rate/range
   // CFG3     | write 0x1440, rounding
   // WAIT_INT | idle until synchronised interrupt is high
   // RD_L     | read yaw low byte
   // RD_H     | read yaw high byte, publish sample

   localparam logic [15:0] TIMER_TC = 16'(INIT_CYCLES - 1);
   localparam logic [15:0] CMD_CFG1 = 16'h0D02;
   localparam logic [15:0] CMD_CFG2 = 16'h1160;
   localparam logic [15:0] CMD_CFG3 = 16'h1440;
   localparam logic [15:0] CMD_RD_L = 16'hA600;
   localparam logic [15:0] CMD_RD_H = 16'hA700;

   typedef enum logic [2:0] {
      PWR_WAIT, CFG1, CFG2, CFG3, WAIT_INT, RD_L, RD_H
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic        int_ff1_q, int_ff2_q;
   logic        wrt_q, wrt_d;
   logic [15:0] wt_data_q, wt_data_d;
   logic [7:0]  low_q, low_d;
   logic [15:0] yaw_q, yaw_d;
   logic        vld_q, vld_d;
   logic        xfer_done;

   // The monarch's done from the previous transaction is still high in the wrt cycle.
   assign xfer_done = done_i & ~wrt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_ff1_q <= 1'b0;
         int_ff2_q <= 1'b0;
      end else begin
         int_ff1_q <= int_i;
         int_ff2_q <= int_ff1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= PWR_WAIT;
         timer_q   <= 16'h0000;
         wrt_q     <= 1'b0;
         wt_data_q <= 16'h0000;
         low_q     <= 8'h00;
         yaw_q     <= 16'h0000;
         vld_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         wrt_q     <= wrt_d;
         wt_data_q <= wt_data_d;
         low_q     <= low_d;
         yaw_q     <= yaw_d;
         vld_q     <= vld_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      wrt_d     = 1'b0;
      wt_data_d = wt_data_q;
      low_d     = low_q;
      yaw_d     = yaw_q;
      vld_d     = 1'b0;
      case (state_q)
         PWR_WAIT: begin
            timer_d = timer_q + 16'd1;
            if (timer_q == TIMER_TC) begin
               state_d   = CFG1;
               wrt_d     = 1'b1;
               wt_data_d = CMD_CFG1;
            end
         end
         CFG1: if (xfer_done) begin
            state_d   = CFG2;
            wrt_d     = 1'b1;
            wt_data_d = CMD_CFG2;
         end
         CFG2: if (xfer_done) begin
            state_d   = CFG3;
            wrt_d     = 1'b1;
            wt_data_d = CMD_CFG3;
         end
         CFG3: if (xfer_done) state_d = WAIT_INT;
         WAIT_INT: if (int_ff2_q) begin
            state_d   = RD_L;
            wrt_d     = 1'b1;
            wt_data_d = CMD_RD_L;
         end
         RD_L: if (xfer_done) begin
            low_d     = rd_data_i[7:0];
            state_d   = RD_H;
            wrt_d     = 1'b1;
            wt_data_d = CMD_RD_H;
         end
         RD_H: if (xfer_done) begin
            yaw_d   = {rd_data_i[7:0], low_q};
            vld_d   = 1'b1;
            state_d = WAIT_INT;
         end
         default: state_d = PWR_WAIT;
      endcase
   end

   assign wrt_o     = wrt_q;
   assign wt_data_o = wt_data_q;
   assign yaw_rt_o  = yaw_q;
   assign vld_o     = vld_q;

endmodule
